// File: rtl/cfi_shadow_stack_backend.sv
`default_nettype none
//============================================================================
// Module   : cfi_shadow_stack_pkg / cfi_shadow_stack_backend
// Purpose  : Checking back-end of the CFI stage. Drains cfi_log_t records
//            from the fall-through CFI queue and keeps a hardware shadow
//            stack of return addresses. Calls push their return address,
//            returns pop and compare, and branches/jumps retire unchecked.
//            A return-address mismatch raises a sticky CFI fault toward
//            commit, held until acknowledged.
// Ports    : clk_i          - clock
//            rst_i          - asynchronous active-high reset
//            enable_i       - checking enable (0: records drained, discarded)
//            flush_i        - context switch; clears the shadow stack
//            log_i          - CFI queue head record
//            queue_empty_i  - CFI queue empty
//            queue_pop_o    - pop the queue head this cycle
//            fault_ack_i    - commit has taken the fault
//            cfi_fault_o    - CFI violation exception (valid/cause/tval)
//            stack_depth_o  - number of valid shadow-stack entries
// Revision : 1.0 - initial release
//============================================================================

package cfi_shadow_stack_pkg;
   localparam int CFI_XLEN = 64;

   typedef enum logic [1:0] {
      CF_BRANCH = 2'd0,
      CF_JUMP   = 2'd1,
      CF_CALL   = 2'd2,
      CF_RETURN = 2'd3
   } cf_type_e;

   typedef struct packed {
      cf_type_e              cf_type;
      logic [CFI_XLEN-1:0]   pc;
      logic [CFI_XLEN-1:0]   target;
      logic                  is_rvc;
   } cfi_log_t;

   typedef struct packed {
      logic                  valid;
      logic [CFI_XLEN-1:0]   cause;
      logic [CFI_XLEN-1:0]   tval;
   } exception_t;
endpackage

module cfi_shadow_stack_backend
   import cfi_shadow_stack_pkg::*;
#(
   parameter int DEPTH           = 16,
   parameter int XLEN            = CFI_XLEN,
   parameter bit UNDERFLOW_FAULT = 1'b1
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      enable_i,
   input  logic                      flush_i,
   input  cfi_log_t                  log_i,
   input  logic                      queue_empty_i,
   output logic                      queue_pop_o,
   input  logic                      fault_ack_i,
   output exception_t                cfi_fault_o,
   output logic [$clog2(DEPTH):0]    stack_depth_o
);

   localparam int                 c_sp_w      = $clog2(DEPTH);
   localparam logic [c_sp_w-1:0]  c_sp_one    = c_sp_w'(1);
   localparam logic [c_sp_w:0]    c_cnt_one   = (c_sp_w+1)'(1);
   localparam logic [c_sp_w:0]    c_cnt_full  = (c_sp_w+1)'(DEPTH);
   localparam logic [XLEN-1:0]    c_ret_rvc   = XLEN'(2);
   localparam logic [XLEN-1:0]    c_ret_std   = XLEN'(4);
   localparam logic [CFI_XLEN-1:0] c_cause_sw_check = CFI_XLEN'(18);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CHECK = 2'd1,
      ST_FAULT = 2'd2
   } state_e;

   state_e              r_state;
   state_e              w_state_next;
   cfi_log_t            r_rec;
   logic [c_sp_w-1:0]   r_sp;
   logic [c_sp_w:0]     r_count;
   logic [XLEN-1:0]     r_stack [DEPTH];

   logic                w_capture;
   logic                w_push;
   logic                w_pop;
   logic [c_sp_w-1:0]   w_sp_dec;
   logic [XLEN-1:0]     w_ret_addr;
   logic                w_ret_match;

   assign w_sp_dec    = r_sp - c_sp_one;
   assign w_ret_addr  = r_rec.pc[XLEN-1:0] + (r_rec.is_rvc ? c_ret_rvc : c_ret_std);
   // Top-of-stack read is only meaningful when count > 0; the CHECK logic
   // never acts on it otherwise.
   assign w_ret_match = (r_rec.target[XLEN-1:0] == r_stack[w_sp_dec]);

   //-------------------------------------------------------------------------
   // Next-state and output decode
   //-------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      w_capture    = 1'b0;
      w_push       = 1'b0;
      w_pop        = 1'b0;
      queue_pop_o  = 1'b0;

      case (r_state)
         ST_IDLE: begin
            // Flush takes the cycle: the head stays in the queue.
            if (!queue_empty_i && !flush_i) begin
               w_capture    = 1'b1;
               w_state_next = ST_CHECK;
            end
         end
         ST_CHECK: begin
            w_state_next = ST_IDLE;
            if (!flush_i && enable_i) begin
               case (r_rec.cf_type)
                  CF_CALL: begin
                     w_push = 1'b1;
                  end
                  CF_RETURN: begin
                     if (r_count != '0) begin
                        w_pop = 1'b1;
                        if (!w_ret_match) begin
                           w_state_next = ST_FAULT;
                        end
                     end else if (UNDERFLOW_FAULT) begin
                        w_state_next = ST_FAULT;
                     end
                  end
                  default: begin
                  end
               endcase
            end
         end
         ST_FAULT: begin
            if (fault_ack_i) begin
               w_state_next = ST_IDLE;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase

      // Reset is asynchronous, so the combinational pop is masked directly
      // to keep it low for the whole reset pulse.
      queue_pop_o = w_capture & ~rst_i;
   end

   // Fault fields are derived from registered state only, so they are
   // stable for the whole FAULT residency and clear with reset.
   always_comb begin
      cfi_fault_o       = '0;
      if (r_state == ST_FAULT) begin
         cfi_fault_o.valid = 1'b1;
         cfi_fault_o.cause = c_cause_sw_check;
         cfi_fault_o.tval  = r_rec.target;
      end
   end

   assign stack_depth_o = r_count;

   //-------------------------------------------------------------------------
   // State register
   //-------------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   //-------------------------------------------------------------------------
   // Captured record, stack pointer and occupancy count
   //-------------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_rec   <= '0;
         r_sp    <= '0;
         r_count <= '0;
      end else begin
         if (w_capture) begin
            r_rec <= log_i;
         end
         // Flush clears the stack from any state, including FAULT.
         if (flush_i) begin
            r_sp    <= '0;
            r_count <= '0;
         end else if (w_push) begin
            r_sp <= r_sp + c_sp_one;
            // A full stack wraps and overwrites its oldest entry.
            if (r_count != c_cnt_full) begin
               r_count <= r_count + c_cnt_one;
            end
         end else if (w_pop) begin
            r_sp    <= w_sp_dec;
            r_count <= r_count - c_cnt_one;
         end
      end
   end

   //-------------------------------------------------------------------------
   // Stack storage (no reset needed; occupancy is tracked by r_count)
   //-------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_stack[r_sp] <= w_ret_addr;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cfi_shadow_stack_backend.sv
`default_nettype none
//============================================================================
// Module   : tb_cfi_shadow_stack_backend
// Purpose  : Self-checking bench for cfi_shadow_stack_backend. A reference
//            shadow-stack model produces the expected outcome of each
//            record; outcomes are queued when a record is popped and
//            compared once the DUT has finished checking it.
// Revision : 1.0 - initial release
//============================================================================
module tb_cfi_shadow_stack_backend;
   import cfi_shadow_stack_pkg::*;

   localparam int DEPTH = 16;
   localparam int DW    = $clog2(DEPTH) + 1;

   logic          clk;
   logic          rst;
   logic          enable;
   logic          flush;
   logic          qempty;
   logic          ack;
   cfi_log_t      log_in;
   logic          pop;
   exception_t    fault;
   logic [DW-1:0] depth;

   logic          nf_qempty;
   cfi_log_t      nf_log;
   logic          nf_pop;
   exception_t    nf_fault;
   logic [DW-1:0] nf_depth;

   typedef struct {
      logic        fault;
      logic [63:0] tval;
      int          depth;
   } exp_t;

   exp_t        exp_q[$];
   logic [63:0] model_stack[$];
   int          n_checks = 0;
   int          n_errors = 0;
   time         pop_time = 0;

   cfi_shadow_stack_backend #(.DEPTH(DEPTH), .XLEN(64), .UNDERFLOW_FAULT(1'b1)) dut (
      .clk_i(clk), .rst_i(rst), .enable_i(enable), .flush_i(flush),
      .log_i(log_in), .queue_empty_i(qempty), .queue_pop_o(pop),
      .fault_ack_i(ack), .cfi_fault_o(fault), .stack_depth_o(depth)
   );

   cfi_shadow_stack_backend #(.DEPTH(DEPTH), .XLEN(64), .UNDERFLOW_FAULT(1'b0)) dut_nf (
      .clk_i(clk), .rst_i(rst), .enable_i(1'b1), .flush_i(1'b0),
      .log_i(nf_log), .queue_empty_i(nf_qempty), .queue_pop_o(nf_pop),
      .fault_ack_i(1'b0), .cfi_fault_o(nf_fault), .stack_depth_o(nf_depth)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached (got timeout, need finish)");
      $fatal(1);
   end

   function automatic cfi_log_t mk(input cf_type_e t, input logic [63:0] pc,
                                   input logic [63:0] tgt, input logic rvc);
      cfi_log_t r;
      r.cf_type = t;
      r.pc      = pc;
      r.target  = tgt;
      r.is_rvc  = rvc;
      return r;
   endfunction

   // Reference model: circular stack of DEPTH entries, oldest dropped on overflow.
   function automatic exp_t model_apply(input cfi_log_t r, input logic en, input logic uf);
      exp_t e;
      e.fault = 1'b0;
      e.tval  = r.target;
      if (en) begin
         case (r.cf_type)
            CF_CALL: begin
               if (model_stack.size() == DEPTH) void'(model_stack.pop_front());
               model_stack.push_back(r.pc + (r.is_rvc ? 64'd2 : 64'd4));
            end
            CF_RETURN: begin
               if (model_stack.size() > 0) begin
                  if (model_stack.pop_back() != r.target) e.fault = 1'b1;
               end else begin
                  e.fault = uf;
               end
            end
            default: ;
         endcase
      end
      e.depth = model_stack.size();
      return e;
   endfunction

   // Present one record, wait (bounded) for the pop, then check the outcome.
   task automatic send(input cfi_log_t r);
      exp_t e;
      bit   seen;
      seen   = 1'b0;
      log_in = r;
      qempty = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
         #1;
         if (pop === 1'b1) seen = 1'b1;
         else begin
            @(posedge clk);
            #1;
         end
      end
      n_checks++;
      if (!seen) begin
         n_errors++;
         $display("FAIL pop_timeout: queue_pop_o=%b, need 1 within 8 cycles", pop);
         qempty = 1'b1;
         return;
      end
      pop_time = $time;
      exp_q.push_back(model_apply(r, enable, 1'b1));
      @(posedge clk);
      #1;
      qempty = 1'b1;
      n_checks++;
      if (pop !== 1'b0) begin
         n_errors++;
         $display("FAIL pop_in_check: queue_pop_o=%b, need 0", pop);
      end
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if (fault.valid !== e.fault) begin
         n_errors++;
         $display("FAIL fault_valid: got %b, need %b (type %0d target %h)",
                  fault.valid, e.fault, r.cf_type, r.target);
      end
      n_checks++;
      if (depth !== DW'(e.depth)) begin
         n_errors++;
         $display("FAIL depth: got %0d, need %0d", depth, e.depth);
      end
      if (e.fault) begin
         n_checks++;
         if (fault.cause !== 64'd18 || fault.tval !== e.tval) begin
            n_errors++;
            $display("FAIL fault_fields: cause %0d tval %h, need cause 18 tval %h",
                     fault.cause, fault.tval, e.tval);
         end
      end
   endtask

   task automatic ack_fault();
      ack = 1'b1;
      @(posedge clk);
      #1;
      ack = 1'b0;
      n_checks++;
      if (fault.valid !== 1'b0) begin
         n_errors++;
         $display("FAIL ack_release: valid %b, need 0", fault.valid);
      end
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      enable    = 1'b1;
      flush     = 1'b0;
      ack       = 1'b0;
      log_in    = mk(CF_CALL, 64'h10, 64'h0, 1'b0);
      qempty    = 1'b0;
      nf_log    = mk(CF_CALL, 64'h10, 64'h0, 1'b0);
      nf_qempty = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (pop !== 1'b0 || nf_pop !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_pop: pop %b/%b, need 0/0", pop, nf_pop);
      end
      n_checks++;
      if (fault !== '0 || depth !== '0) begin
         n_errors++;
         $display("FAIL reset_state: fault %h depth %0d, need 0 and 0", fault, depth);
      end
      qempty    = 1'b1;
      nf_qempty = 1'b1;
      rst       = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_call_return();
      time t1;
      send(mk(CF_CALL, 64'h8000_0100, 64'h0, 1'b0));
      t1 = pop_time;
      send(mk(CF_RETURN, 64'h0, 64'h8000_0104, 1'b0));
      n_checks++;
      if (pop_time - t1 != 20) begin
         n_errors++;
         $display("FAIL pop_spacing: got %0t, need 20", pop_time - t1);
      end
   endtask

   task automatic test_mismatch();
      send(mk(CF_CALL, 64'h8000_0200, 64'h0, 1'b1));
      send(mk(CF_RETURN, 64'h0, 64'h8000_0206, 1'b0));
      // Queue non-empty while faulted: must hold and never pop.
      log_in = mk(CF_BRANCH, 64'h300, 64'h400, 1'b0);
      qempty = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_checks++;
         if (fault.valid !== 1'b1 || fault.tval !== 64'h8000_0206 ||
             fault.cause !== 64'd18 || pop !== 1'b0) begin
            n_errors++;
            $display("FAIL fault_hold: valid %b tval %h cause %0d pop %b, need 1 80000206 18 0",
                     fault.valid, fault.tval, fault.cause, pop);
         end
         @(posedge clk);
         #1;
      end
      ack_fault();
      n_checks++;
      if (pop !== 1'b1) begin
         n_errors++;
         $display("FAIL pop_after_ack: pop %b, need 1", pop);
      end
      send(mk(CF_BRANCH, 64'h300, 64'h400, 1'b0));
   endtask

   task automatic test_overflow();
      for (int i = 0; i <= 16; i++) send(mk(CF_CALL, 64'h100 * i, 64'h0, 1'b0));
      for (int i = 16; i >= 1; i--) send(mk(CF_RETURN, 64'h0, 64'h100 * i + 64'h4, 1'b0));
      send(mk(CF_RETURN, 64'h0, 64'h4, 1'b0));
      ack_fault();
   endtask

   task automatic test_underflow_silent();
      exp_t e;
      nf_log    = mk(CF_RETURN, 64'h0, 64'h1234, 1'b0);
      nf_qempty = 1'b0;
      #1;
      n_checks++;
      if (nf_pop !== 1'b1) begin
         n_errors++;
         $display("FAIL nf_pop: pop %b, need 1", nf_pop);
      end
      e.fault = 1'b0;
      e.tval  = 64'h1234;
      e.depth = 0;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      nf_qempty = 1'b1;
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if (nf_fault.valid !== e.fault || nf_depth !== DW'(e.depth)) begin
         n_errors++;
         $display("FAIL nf_underflow: valid %b depth %0d, need %b %0d",
                  nf_fault.valid, nf_depth, e.fault, e.depth);
      end
   endtask

   task automatic test_flush();
      for (int i = 1; i <= 3; i++) send(mk(CF_CALL, 64'h1000 * i, 64'h0, 1'b1));
      send(mk(CF_BRANCH, 64'h5000, 64'h6000, 1'b0));
      send(mk(CF_JUMP, 64'h5004, 64'h7000, 1'b1));
      log_in = mk(CF_CALL, 64'h9000, 64'h0, 1'b0);
      qempty = 1'b0;
      flush  = 1'b1;
      #1;
      n_checks++;
      if (pop !== 1'b0) begin
         n_errors++;
         $display("FAIL flush_pop: pop %b, need 0", pop);
      end
      @(posedge clk);
      #1;
      flush  = 1'b0;
      qempty = 1'b1;
      model_stack.delete();
      n_checks++;
      if (depth !== '0) begin
         n_errors++;
         $display("FAIL flush_depth: depth %0d, need 0", depth);
      end
      send(mk(CF_RETURN, 64'h0, 64'h1002, 1'b0));
      ack_fault();
   endtask

   task automatic test_disable();
      send(mk(CF_CALL, 64'hA000, 64'h0, 1'b0));
      enable = 1'b0;
      send(mk(CF_CALL, 64'hB000, 64'h0, 1'b0));
      send(mk(CF_RETURN, 64'h0, 64'hDEAD, 1'b0));
      enable = 1'b1;
      send(mk(CF_RETURN, 64'h0, 64'hA004, 1'b0));
   endtask

   task automatic test_reset_midway();
      send(mk(CF_CALL, 64'h2000, 64'h0, 1'b0));
      log_in = mk(CF_CALL, 64'h3000, 64'h0, 1'b0);
      qempty = 1'b0;
      #1;
      @(posedge clk);
      #1;
      qempty = 1'b1;
      rst    = 1'b1;
      #1;
      n_checks++;
      if (depth !== '0 || fault !== '0 || pop !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_in_check: depth %0d fault %h pop %b, need all 0", depth, fault, pop);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_stack.delete();
      send(mk(CF_RETURN, 64'h0, 64'h55, 1'b0));
      #1;
      rst = 1'b1;
      #1;
      n_checks++;
      if (fault !== '0 || depth !== '0) begin
         n_errors++;
         $display("FAIL reset_in_fault: fault %h depth %0d, need 0 and 0", fault, depth);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      send(mk(CF_CALL, 64'h40, 64'h0, 1'b0));
   endtask

   initial begin
      test_reset();
      test_call_return();
      test_mismatch();
      test_overflow();
      test_underflow_silent();
      test_flush();
      test_disable();
      test_reset_midway();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
